dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word access with RISC-V funct3 semantics and returns read data plus an error flag over a second valid/ready handshake.
- Replaces the zero-latency data memory when the core moves to a multi-cycle memory stage.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array.
- WAIT_CYCLES, 2: wait states between request accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_funct3  input  3  access size/sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
- rsp_err  output  1  access faulted; no state change occurred.

Behaviour:
- Reset values:
  - FSM to IDLE.
  - req_ready = 1 (IDLE is combinational from state).
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - The storage array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture we/addr/wdata/funct3.
  - If WAIT_CYCLES > 0, go to WAIT with counter = WAIT_CYCLES-1; otherwise perform the access and go to RESP.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access on that edge and go to RESP.
- RESP:
  - req_ready = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid = 0 on the next cycle.
- Latency: request accepted at edge T gives rsp_valid high in the cycle after edge T+WAIT_CYCLES.
  - Back-to-back throughput is one request per WAIT_CYCLES+2 cycles when rsp_ready is held high.
  - There is no combinational path from req_* to rsp_*.
- Access rules (little-endian):
  - Word index = addr[31:2]; byte lane = addr[1:0].
  - LB/LBU select the byte at the lane; LB sign-extends from bit 7, LBU zero-extends.
  - LH/LHU select the half at addr[1]; LH sign-extends from bit 15, LHU zero-extends.
  - SB writes only the addressed byte lane, using wdata[7:0].
  - SH writes lanes {1,0} or {3,2}, using wdata[15:0].
  - SW writes the whole word.
- Error conditions: rsp_err = 1, no array write, rsp_rdata = 0. Any of:
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - addr[31:2] >= DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 > 010.
- Store success response: rsp_err = 0, rsp_rdata = 0.
- Commit point: the array write occurs on the edge entering RESP.
  - Reset asserted in WAIT aborts the store; the array is unchanged.
  - Reset asserted in RESP keeps the committed store but drops the response.
- req_valid while not ready is ignored; the requester must hold the request.
- rsp_ready while rsp_valid = 0 has no effect.

Decomposition:
- Shared package (defines file):
  - funct3 encodings F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encodings ST_IDLE/ST_WAIT/ST_RESP (2-bit).
- Sub-module dmem_byte_lane (combinational):
  - Inputs: addr[1:0], funct3, wdata, old word.
  - Outputs: merged write word, extended load data, alignment error.
- Top level holds the FSM, the counter, the capture registers and the array.

Test Plan:
- WAIT_CYCLES=2, rsp_ready held 1: SW 0xDEADBEEF @0x10 accepted at edge T gives rsp_valid in the cycle after edge T+2, err=0, rdata=0. Then LW @0x10 returns rdata=0xDEADBEEF.
- After the word above, LB @0x13 gives 0xFFFFFFDE, LBU @0x13 gives 0x000000DE, LH @0x12 gives 0xFFFFDEAD. SB 0x55 @0x11 followed by LW @0x10 gives 0xDEAD55EF.
- Error cases:
  - LW @0x12 gives err=1, rdata=0.
  - SH 0x1234 @0x11 gives err=1; LW @0x10 afterwards is unchanged.
  - LW @(DEPTH_WORDS*4) gives err=1.
  - Load funct3=011 gives err=1.
- Backpressure: rsp_ready held 0 for 5 cycles keeps rsp_valid, rdata and err stable with req_ready=0. rsp_ready=1 then gives IDLE next cycle and a new request accepted the following edge.
- WAIT_CYCLES=0: the request at edge T gives rsp_valid in the cycle after T; 3 back-to-back LWs complete in 6 cycles.
- Reset:
  - rst pulsed in WAIT of SW 0xA5A5A5A5 @0x20 gives rsp_valid=0, req_ready=1 immediately (asynchronously); LW @0x20 afterwards returns the old value.
  - rst pulsed in RESP of the same store leaves LW @0x20 = 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: funct3 access sizes,
// FSM states and the funct3 legality check.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Stores only know B/H/W; loads additionally allow the unsigned variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Little-endian lane steering: merges store data into the old word and
// extracts/extends load data; flags misaligned halfword/word accesses.
module dmem_byte_lane
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = old_word[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    wr_word  = old_word;
    ld_data  = '0;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wr_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ld_data = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      end
      F3_H, F3_HU: begin
        misalign = addr_lo[0];
        if (addr_lo[1]) wr_word[31:16] = wdata[15:0];
        else            wr_word[15:0]  = wdata[15:0];
        ld_data = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      end
      F3_W: begin
        misalign = (addr_lo != 2'b00);
        wr_word  = wdata;
        ld_data  = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states,
// registered response with error flag. The array write commits entering RESP.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [2:0]  cap_f3;

  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic [29:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic [31:0] old_word, wr_word, ld_data;
  logic        misalign, acc_err, do_access, accept;

  logic [31:0] mem [DEPTH_WORDS];

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The sender holds valid and payload until then; ready never depends on
  // valid, so req_ready/rsp_valid are pure decodes of the state register.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign dbg_state = state;
  assign accept    = req_ready && req_valid;

  // With zero wait states the access uses the live request in IDLE.
  assign acc_we    = (state == ST_IDLE) ? req_we     : cap_we;
  assign acc_addr  = (state == ST_IDLE) ? req_addr   : cap_addr;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata  : cap_wdata;
  assign acc_f3    = (state == ST_IDLE) ? req_funct3 : cap_f3;

  assign word_idx = acc_addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign old_word = mem[mem_idx];
  assign acc_err  = misalign || (word_idx >= 30'(DEPTH_WORDS)) || f3_illegal(acc_we, acc_f3);

  dmem_byte_lane u_lane (
    .addr_lo  (acc_addr[1:0]),
    .funct3   (acc_f3),
    .wdata    (acc_wdata),
    .old_word (old_word),
    .wr_word  (wr_word),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  always_comb begin
    state_nxt = state;
    do_access = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        do_access = (WAIT_CYCLES == 0);
      end
      ST_WAIT: if (cnt == 4'd0) begin
        state_nxt = ST_RESP;
        do_access = 1'b1;
      end
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_f3    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_f3    <= req_funct3;
        if (WAIT_CYCLES > 0) cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'd0 : ld_data;
      end
    end
  end

  // Storage is not reset; a reset during WAIT must not let the store land.
  always_ff @(posedge clk) begin
    if (do_access && !rst && acc_we && !acc_err) mem[mem_idx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance for function,
// errors, backpressure and reset; WAIT_CYCLES=0 instance for latency/throughput.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int W = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b1;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [2:0]  z_req_funct3 = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .req_funct3(z_req_funct3), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request and returns just after the accepting edge.
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output int waited);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int n;
    bit seen;
    logic [W-1:0] e;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
      chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int w;
    exp_q.push_back({exp_err, exp_rdata});
    drive_req(we, addr, wdata, f3, w);
    collect(tag, 2);
  endtask

  initial begin : stim
    int w, n, got;
    logic [W-1:0] e;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Basic word store/load and lane extraction
    xact("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b0, 32'h0);
    xact("lw_10", 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 32'hDEADBEEF);
    xact("lb_13", 1'b0, 32'h13, 32'h0, F3_B, 1'b0, 32'hFFFFFFDE);
    xact("lbu_13", 1'b0, 32'h13, 32'h0, F3_BU, 1'b0, 32'h000000DE);
    xact("lh_12", 1'b0, 32'h12, 32'h0, F3_H, 1'b0, 32'hFFFFDEAD);
    xact("lhu_10", 1'b0, 32'h10, 32'h0, F3_HU, 1'b0, 32'h0000BEEF);
    xact("sb_11", 1'b1, 32'h11, 32'h00000055, F3_B, 1'b0, 32'h0);
    xact("lw_10b", 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 32'hDEAD55EF);

    // Error cases
    xact("lw_mis", 1'b0, 32'h12, 32'h0, F3_W, 1'b1, 32'h0);
    xact("sh_mis", 1'b1, 32'h11, 32'h00001234, F3_H, 1'b1, 32'h0);
    xact("lw_after_sh", 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 32'hDEAD55EF);
    xact("lw_oob", 1'b0, 32'd4096, 32'h0, F3_W, 1'b1, 32'h0);
    xact("ld_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 1'b1, 32'h0);
    xact("st_f3_100", 1'b1, 32'h10, 32'h12345678, 3'b100, 1'b1, 32'h0);
    xact("sh_12", 1'b1, 32'h12, 32'hFFFF1234, F3_H, 1'b0, 32'h0);
    xact("lw_10c", 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 32'h123455EF);

    // Backpressure: response must hold while rsp_ready is low
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h123455EF});
    drive_req(1'b0, 32'h10, 32'h0, F3_W, w);
    collect("bp", 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h123455EF);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    exp_q.push_back({1'b0, 32'h000000EF});
    drive_req(1'b0, 32'h10, 32'h0, F3_BU, w);
    chk("bp_next_accept_wait", 32'(w), 32'd0);
    collect("bp_next", 2);

    // Reset during WAIT aborts the store
    xact("sw_20_init", 1'b1, 32'h20, 32'h11112222, F3_W, 1'b0, 32'h0);
    @(negedge clk);
    drive_req(1'b1, 32'h20, 32'hA5A5A5A5, F3_W, w);
    @(negedge clk);
    chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact("lw_20_old", 1'b0, 32'h20, 32'h0, F3_W, 1'b0, 32'h11112222);

    // Reset during RESP keeps the committed store
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    drive_req(1'b1, 32'h20, 32'hA5A5A5A5, F3_W, w);
    collect("sw_20_resp", 2);
    rst = 1'b1;
    #1;
    chk("rstr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstr_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    xact("lw_20_new", 1'b0, 32'h20, 32'h0, F3_W, 1'b0, 32'hA5A5A5A5);

    // Zero wait states: latency and back-to-back throughput
    @(negedge clk);
    z_req_we = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h0BADF00D; z_req_funct3 = F3_W;
    z_req_valid = 1'b1;
    chk("z_ready", 32'(z_req_ready), 32'd1);
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_sw_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_sw_err", 32'(z_rsp_err), 32'd0);
    @(negedge clk);
    z_req_we = 1'b0;
    z_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'h0BADF00D});
    n = 0;
    got = 0;
    while (got < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (z_rsp_valid) begin
        got++;
        e = exp_q.pop_front();
        chk("z_lw_err", 32'(z_rsp_err), 32'(e[32]));
        chk("z_lw_rdata", z_rsp_rdata, e[31:0]);
        if (got == 3) z_req_valid = 1'b0;
      end
    end
    chk("z_b2b_got", 32'(got), 32'd3);
    chk("z_b2b_cycles", 32'(n), 32'd5);
    @(negedge clk);
    chk("z_idle_after", 32'(z_dbg_state), 32'(ST_IDLE));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
